// File: rtl/ram8_16_pkg.sv
// Shared constants and word/address types for the 8 x 16-bit register bank.
package ram8_16_pkg;
    localparam int WORD_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    // Index 0 is the leftmost (most significant) bit, matching the gate library ordering.
    typedef logic [0:WORD_W-1] word_t;
    typedef logic [0:ADDR_W-1] addr_t;

    localparam word_t RST_VAL = 16'h0000;
endpackage

// File: rtl/ram8_16_if.sv
// Data/address/load bus of the register bank; the bank itself is the slave.
interface ram8_16_if;
    import ram8_16_pkg::*;

    word_t in_d;
    addr_t in_addr;
    logic  in_load;
    word_t out_q;

    modport master (output in_d, output in_addr, output in_load, input out_q);
    modport slave  (input in_d, input in_addr, input in_load, output out_q);
endinterface

// File: rtl/ram8_16_dmux8way.sv
// 1-to-8 demux of the load strobe; select bit 0 is the MSB of the line index.
module ram8_16_dmux8way
    import ram8_16_pkg::*;
(
    input  logic             in_in,
    input  addr_t            in_sel,
    output logic [0:DEPTH-1] out_lines
);
    addr_t w_sel_n;

    assign w_sel_n = ~in_sel;

    for (genvar k = 0; k < DEPTH; k++) begin : g_line
        localparam logic [2:0] K = 3'(k);
        assign out_lines[k] = in_in
                            & (K[2] ? in_sel[0] : w_sel_n[0])
                            & (K[1] ? in_sel[1] : w_sel_n[1])
                            & (K[0] ? in_sel[2] : w_sel_n[2]);
    end
endmodule

// File: rtl/ram8_16_mux16.sv
// 16-bit 2-to-1 mux used as the read-tree element.
module ram8_16_mux16
    import ram8_16_pkg::*;
(
    input  word_t in_a,
    input  word_t in_b,
    input  logic  in_sel,
    output word_t out_q
);
    assign out_q = in_sel ? in_b : in_a;
endmodule

// File: rtl/ram8_16_reg16.sv
// 16-bit register with async active-low clear and load enable, one hold/load mux per bit.
module ram8_16_reg16
    import ram8_16_pkg::*;
(
    input  logic  in_clk,
    input  logic  in_rst_n,
    input  logic  in_load,
    input  word_t in_d,
    output word_t out_q
);
    word_t r_q;
    word_t w_next;

    for (genvar i = 0; i < WORD_W; i++) begin : g_bit
        assign w_next[i] = in_load ? in_d[i] : r_q[i];

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                r_q[i] <= RST_VAL[i];
            end else begin
                r_q[i] <= w_next[i];
            end
        end
    end

    assign out_q = r_q;
endmodule

// File: rtl/ram8_16.sv
// 8-word x 16-bit register bank: demuxed load into eight registers, 3-level mux tree read-back.
module ram8_16
    import ram8_16_pkg::*;
(
    input  logic       in_clk,
    input  logic       in_rst_n,
    ram8_16_if.slave   bus
);
    logic [0:DEPTH-1] w_load;
    word_t            w_word [0:DEPTH-1];
    word_t            w_lvl1 [0:3];
    word_t            w_lvl2 [0:1];

    ram8_16_dmux8way u_dmux (
        .in_in     (bus.in_load),
        .in_sel    (bus.in_addr),
        .out_lines (w_load)
    );

    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        ram8_16_reg16 u_reg (
            .in_clk   (in_clk),
            .in_rst_n (in_rst_n),
            .in_load  (w_load[k]),
            .in_d     (bus.in_d),
            .out_q    (w_word[k])
        );
    end

    // Read tree: address LSB (bit 2) picks within pairs, MSB (bit 0) picks the half.
    for (genvar j = 0; j < 4; j++) begin : g_lvl1
        ram8_16_mux16 u_mux (
            .in_a   (w_word[2*j]),
            .in_b   (w_word[2*j+1]),
            .in_sel (bus.in_addr[2]),
            .out_q  (w_lvl1[j])
        );
    end

    for (genvar j = 0; j < 2; j++) begin : g_lvl2
        ram8_16_mux16 u_mux (
            .in_a   (w_lvl1[2*j]),
            .in_b   (w_lvl1[2*j+1]),
            .in_sel (bus.in_addr[1]),
            .out_q  (w_lvl2[j])
        );
    end

    ram8_16_mux16 u_mux_root (
        .in_a   (w_lvl2[0]),
        .in_b   (w_lvl2[1]),
        .in_sel (bus.in_addr[0]),
        .out_q  (bus.out_q)
    );
endmodule

// File: tb/tb_ram8_16.sv
// Directed bench for ram8_16 with a reference word array and an expected-value queue.
module tb_ram8_16;
    import ram8_16_pkg::*;

    logic clk;
    logic rst_n;
    logic clk_en;

    ram8_16_if bus ();

    ram8_16 dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 begin
        if (clk_en) clk = ~clk;
    end

    logic [15:0] mem [0:7];
    logic [15:0] sb_exp [$];
    string       sb_tag [$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Illegal stimulus: unknown address while a write is requested.
    always @(posedge clk) begin
        if (bus.in_load === 1'b1 && rst_n === 1'b1) begin
            assert (!$isunknown(bus.in_addr)) else begin
                n_err++;
                $error("FAIL x_addr: observed addr %b with load=1 required known", bus.in_addr);
            end
        end
    end

    task automatic push(input logic [15:0] exp, input string tag);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
    endtask

    task automatic check();
        logic [15:0] exp;
        logic [15:0] obs;
        string       tag;
        exp = sb_exp.pop_front();
        tag = sb_tag.pop_front();
        obs = bus.out_q;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read(input int a, input string tag);
        bus.in_addr = 3'(a);
        #1;
        push(mem[a], $sformatf("%s_a%0d", tag, a));
        check();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 8; a++) read(a, tag);
    endtask

    task automatic write(input int a, input logic [15:0] d);
        @(negedge clk);
        bus.in_addr = 3'(a);
        bus.in_d    = d;
        bus.in_load = 1'b1;
        @(negedge clk);
        bus.in_load = 1'b0;
        mem[a] = d;
    endtask

    initial begin
        clk         = 1'b0;
        clk_en      = 1'b0;
        rst_n       = 1'b1;
        bus.in_addr = 3'd0;
        bus.in_d    = 16'h0000;
        bus.in_load = 1'b0;
        for (int a = 0; a < 8; a++) mem[a] = 16'h0000;

        // Reset with no clock: cleared immediately and while held.
        #3 rst_n = 1'b0;
        #2;
        sweep("rst_held");
        rst_n = 1'b1;
        #2;
        sweep("rst_rel");

        clk_en = 1'b1;

        // Write all, read all.
        for (int k = 0; k < 8; k++) write(k, 16'h1111 * k[15:0]);
        sweep("wr_all");
        bus.in_addr = 3'd5;
        #1;
        push(16'h5555, "word5_const");
        check();

        // Isolation, then hold with different data.
        write(3, 16'hFFFF);
        sweep("iso");
        @(negedge clk);
        bus.in_addr = 3'd3;
        bus.in_d    = 16'hABCD;
        bus.in_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        push(16'hFFFF, "hold_a3");
        #1 check();

        // Read during write at addr 6: old value before edge, new after.
        @(negedge clk);
        bus.in_addr = 3'd6;
        bus.in_d    = 16'hBEEF;
        bus.in_load = 1'b1;
        #1;
        push(16'h6666, "rdw_before");
        check();
        @(posedge clk);
        #1;
        push(16'hBEEF, "rdw_after");
        check();
        bus.in_load = 1'b0;
        mem[6] = 16'hBEEF;

        // Bit order: 0x8001 at addr 3'b100.
        write(4, 16'h8001);
        read(4, "bitord");
        n_cmp++;
        assert (bus.out_q[0] === 1'b1 && bus.out_q[15] === 1'b1) else begin
            n_err++;
            $error("FAIL bitord_ends: observed q[0]=%b q[15]=%b expected 1/1", bus.out_q[0], bus.out_q[15]);
        end
        read(1, "bitord_other");

        // Async reset between edges while a write is pending.
        @(negedge clk);
        bus.in_addr = 3'd2;
        bus.in_d    = 16'h1234;
        bus.in_load = 1'b1;
        #2 rst_n = 1'b0;
        for (int a = 0; a < 8; a++) mem[a] = 16'h0000;
        #1;
        push(16'h0000, "midrst_imm_a2");
        check();
        sweep("midrst_held");
        @(negedge clk);
        bus.in_load = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sweep("midrst_after");

        // Fresh write after reset works normally.
        write(2, 16'h2A2A);
        sweep("post_rst_wr");

        if (sb_exp.size() != 0) begin
            n_err++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb_exp.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish before 50000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram8_16.md
Name: ram8_16

Overview:
- 8-word x 16-bit register bank: the write/demultiplex counterpart of the 16-bit mux gates.
- in_load is steered by in_addr into exactly one of eight 16-bit load registers (the demux side).
- out_q is the addressed word, selected back through a mux tree (the read side).
- First stateful memory block in the gate hierarchy; base element for ram64_16 and larger banks.

Parameters:
- WIDTH, 16, data word width in bits; ports are fixed at 16, and any other value is unsupported.
- DEPTH, 8, number of words; address width is log2(DEPTH) = 3; fixed at 8.

Ports:
- in_clk  input  1  rising-edge clock
- in_rst_n  input  1  asynchronous active-low reset
- in_d  input  [0:15]  write data
- in_addr  input  [0:2]  word address, for both write and read
- in_load  input  1  write enable, sampled on rising in_clk
- out_q  output  [0:15]  contents of word in_addr

Behaviour:
- Reset: in_rst_n low clears all eight words to 16'h0000 immediately, without waiting for in_clk.
  - out_q reads 16'h0000 while reset is held.
  - Reset has priority over in_load.
  - The first rising in_clk after in_rst_n rises behaves normally.
- Write:
  - On rising in_clk with in_rst_n high and in_load = 1, word[in_addr] <= in_d.
  - All other words hold.
  - One word is written per edge; there is no partial or byte write.
- Hold: in_load = 0 at the edge leaves all words unchanged.
- Read is combinational with zero-cycle latency:
  - out_q = word[in_addr], following in_addr changes within the same cycle.
  - Address bit 0 is the MSB of the word index: in_addr = 3'b100 selects word 4.
- Read-during-write, same address:
  - Before the edge, out_q shows the old value.
  - After the edge, out_q shows in_d.
  - There is no write-through bypass.
- Load decode:
  - One-hot over eight register-load lines.
  - in_load = 0 gives all lines 0.
  - No address value produces more than one active line.
- X handling: X on in_addr with in_load = 1 is illegal stimulus; the bench flags it, and the RTL need not define the result.
- Reset mid-operation: asserting in_rst_n within a cycle in which in_load = 1 discards that write; no word retains in_d.
- Bit ordering: index 0 of in_d maps to index 0 of the stored word and of out_q; no reversal anywhere.

Decomposition:
- Shared include (alongside gates.v / gates16.v): constants for word width (16), bank depth (8), address width (3), and reset value 16'h0000.
- Sub-module _reg16: 16-bit register with async active-low clear and load enable. It is built from per-bit load flops, each fed by the existing _mux choosing between hold and in_d.
- Sub-module _dmux8way: 1-to-8 demux of in_load using in_addr, built from _and and _not. Its 3-bit select uses the same [0:2] ordering as in_addr.
- Read path: a tree of seven _mux16 instances (4 + 2 + 1) driven by in_addr bits 2, 1, 0 respectively.
- Top level: instantiates 8 x _reg16, 1 x _dmux8way and the read mux tree; no behavioural logic at the top.

Test Plan:
- Reset then read:
  - Stimulus: pulse in_rst_n low, with no clock running, then sweep in_addr 0..7.
  - Required response: out_q = 16'h0000 for every address.
- Write all, read all:
  - Stimulus: write word k = 16'h1111 * k for k = 0..7 (word 7 = 16'h7777), then sweep in_addr 0..7 with in_load = 0.
  - Required response: each address returns its value; word 5 = 16'h5555.
- Isolation:
  - Stimulus: write 16'hFFFF to addr 3 only.
  - Required response: addrs 0–2 and 4–7 keep their prior values; addr 3 = 16'hFFFF.
  - Repeat with in_load = 0 and in_d = 16'hABCD at addr 3: it stays 16'hFFFF.
- Read-during-write:
  - Stimulus: addr 6 holds 16'h6666; present in_d = 16'hBEEF with in_load = 1 at addr 6.
  - Required response: out_q = 16'h6666 before the edge and 16'hBEEF after it.
- Async reset mid-write:
  - Stimulus: words loaded with distinct values; drop in_rst_n between edges while in_load = 1 and in_d = 16'h1234.
  - Required response: out_q goes to 16'h0000 immediately for every address, and stays 16'h0000 after release until a fresh write.
- Bit-order check:
  - Stimulus: write 16'h8001 to addr 3'b100.
  - Required response: reading addr 4 returns 16'h8001 with out_q[0] = 1 and out_q[15] = 1; reading addr 1 returns its own unchanged value.
